// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter:
// IF port, MEM port and external memory side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_stall;

  logic              err;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ready;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_rdata,
    output if_valid,
    output if_stall,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_valid,
    output mem_stall,
    output err,
    output ext_req,
    output ext_we,
    output ext_addr,
    output ext_wdata,
    input  ext_ready,
    input  ext_rvalid,
    input  ext_rdata
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_rdata,
    input  if_valid,
    input  if_stall,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_valid,
    input  mem_stall,
    input  err,
    input  ext_req,
    input  ext_we,
    input  ext_addr,
    input  ext_wdata,
    output ext_ready,
    output ext_rvalid,
    output ext_rdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between IF and MEM.
// Optional IF starvation guard: ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int TW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic              owner_mem;
  logic [TW-1:0]     tcnt;

  logic              ext_req_q;
  logic              ext_we_q;
  logic [ADDR_W-1:0] ext_addr_q;
  logic [DATA_W-1:0] ext_wdata_q;

  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_valid_q;
  logic              mem_valid_q;
  logic              err_q;

  logic              force_if;
  logic              grant_mem;
  logic              grant_if;

  logic              rsp_done;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  // MEM wins ties unless the guard forces IF
  assign grant_mem = bus.mem_req && !force_if;
  assign grant_if  = bus.if_req &&
                     (!bus.mem_req || force_if);

  // WAIT exit: response data or timeout
  always_comb begin
    rsp_done = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    if (bus.ext_rvalid) begin
      rsp_done = 1'b1;
      if (!ext_we_q) begin
        rsp_data = bus.ext_rdata;
      end
    end else if (TIMEOUT != 0 &&
                 tcnt == TO_LAST) begin
      rsp_done = 1'b1;
      rsp_err  = 1'b1;
    end
  end

  // Access sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      owner_mem   <= 1'b0;
      tcnt        <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            grant_mem: begin
              owner_mem   <= 1'b1;
              ext_req_q   <= 1'b1;
              ext_we_q    <= bus.mem_we;
              ext_addr_q  <= bus.mem_addr;
              ext_wdata_q <= bus.mem_wdata;
              state       <= S_ISSUE;
            end
            grant_if: begin
              owner_mem   <= 1'b0;
              ext_req_q   <= 1'b1;
              ext_we_q    <= 1'b0;
              ext_addr_q  <= bus.if_addr;
              ext_wdata_q <= '0;
              state       <= S_ISSUE;
            end
            default: ;
          endcase
        end
        S_ISSUE: begin
          if (bus.ext_ready) begin
            ext_req_q <= 1'b0;
            tcnt      <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_done) begin
            err_q <= rsp_err;
            if (owner_mem) begin
              mem_valid_q <= 1'b1;
              mem_rdata_q <= rsp_data;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= rsp_data;
            end
            state <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign force_if = bus.if_req && bus.mem_req &&
                    (starve_cnt == SW'(STARVE_MAX));

  // Counts MEM grants taken while IF waits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (grant_if || !bus.if_req) begin
        starve_cnt <= '0;
      end else if (grant_mem) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  // Strict MEM priority; the limit has no effect
  logic starve_unused;
  assign starve_unused = |STARVE_MAX;
  assign force_if      = 1'b0;
`endif

  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req && !if_valid_q;
  assign bus.mem_stall = bus.mem_req && !mem_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter.
// Built with TIMEOUT=8, STARVE_MAX=4.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) bus ();

  unified_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (8),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int          ready_lat   = 0;
  int          rv_lat      = 0;
  bit          rv_never    = 1'b0;
  logic [31:0] rd_word     = '0;
  int          inject_req  = 0;
  int          inject_done = 0;
  int          accepts     = 0;

  // Memory model: ready after ready_lat held
  // cycles, rvalid rv_lat+1 cycles after accept
  initial begin : mem_model
    int hold;
    int rv_cnt;
    hold   = 0;
    rv_cnt = -1;
    bus.ext_ready  = 1'b0;
    bus.ext_rvalid = 1'b0;
    bus.ext_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.ext_ready  = 1'b0;
      bus.ext_rvalid = 1'b0;
      if (inject_req != inject_done) begin
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata  = rd_word;
        inject_done++;
      end
      if (rv_cnt == 0) begin
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata  = rd_word;
        rv_cnt = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
      end
      if (bus.ext_req === 1'b1) begin
        if (hold >= ready_lat) begin
          bus.ext_ready = 1'b1;
          accepts++;
          hold   = 0;
          rv_cnt = rv_never ? -1 : rv_lat;
        end else begin
          hold++;
        end
      end else begin
        hold = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.ext_req, bus.ext_we, bus.if_valid,
         bus.mem_valid, bus.err} !== 5'b0) begin
      errors++;
      $display("FAIL rst_ctl: got %b want 00000",
        {bus.ext_req, bus.ext_we, bus.if_valid,
         bus.mem_valid, bus.err});
    end
    checks++;
    if (bus.ext_addr !== '0 ||
        bus.ext_wdata !== '0) begin
      errors++;
      $display("FAIL rst_ext: addr %h wdata %h want 0",
        bus.ext_addr, bus.ext_wdata);
    end
    checks++;
    if (bus.if_rdata !== '0 ||
        bus.mem_rdata !== '0) begin
      errors++;
      $display("FAIL rst_rdata: if %h mem %h want 0",
        bus.if_rdata, bus.mem_rdata);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ext_req !== 1'b0 ||
        bus.if_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: req %b stall %b want 0",
        bus.ext_req, bus.if_stall);
    end
  endtask

  task automatic test_if_read();
    tick();
    rd_word     = 32'hDEADBEEF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    checks++;
    if (bus.if_stall !== 1'b1 ||
        bus.ext_req !== 1'b0) begin
      errors++;
      $display("FAIL t1_c0: stall %b req %b want 1 0",
        bus.if_stall, bus.ext_req);
    end
    tick();
    checks++;
    if (bus.ext_req !== 1'b1 ||
        bus.ext_addr !== 32'h100 ||
        bus.ext_we !== 1'b0) begin
      errors++;
      $display("FAIL t1_c1: req %b addr %h we %b want 1 100 0",
        bus.ext_req, bus.ext_addr, bus.ext_we);
    end
    tick();
    checks++;
    if (bus.ext_req !== 1'b0 ||
        bus.if_valid !== 1'b0 ||
        bus.if_stall !== 1'b1) begin
      errors++;
      $display("FAIL t1_c2: req %b vld %b stall %b want 0 0 1",
        bus.ext_req, bus.if_valid, bus.if_stall);
    end
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 ||
        bus.if_rdata !== 32'hDEADBEEF ||
        bus.err !== 1'b0 ||
        bus.mem_valid !== 1'b0 ||
        bus.if_stall !== 1'b0) begin
      errors++;
      $display("FAIL t1_c3: vld %b data %h err %b mvld %b stall %b want 1 deadbeef 0 0 0",
        bus.if_valid, bus.if_rdata, bus.err,
        bus.mem_valid, bus.if_stall);
    end
    bus.if_req = 1'b0;
    tick();
    checks++;
    if (bus.if_valid !== 1'b0 ||
        bus.if_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_hold: vld %b data %h want 0 deadbeef",
        bus.if_valid, bus.if_rdata);
    end
  endtask

  task automatic test_both_req();
    tick();
    rd_word       = 32'hCAFEF00D;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h40;
    bus.mem_wdata = 32'h1234;
    tick();
    checks++;
    if (bus.ext_req !== 1'b1 ||
        bus.ext_we !== 1'b1 ||
        bus.ext_addr !== 32'h40 ||
        bus.ext_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL t2_issue: req %b we %b addr %h wd %h want 1 1 40 1234",
        bus.ext_req, bus.ext_we,
        bus.ext_addr, bus.ext_wdata);
    end
    tick();
    tick();
    checks++;
    if (bus.mem_valid !== 1'b1 ||
        bus.mem_rdata !== 32'h0 ||
        bus.if_valid !== 1'b0 ||
        bus.if_stall !== 1'b1) begin
      errors++;
      $display("FAIL t2_mem: mvld %b mdata %h ivld %b istall %b want 1 0 0 1",
        bus.mem_valid, bus.mem_rdata,
        bus.if_valid, bus.if_stall);
    end
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.ext_req !== 1'b1 ||
        bus.ext_we !== 1'b0 ||
        bus.ext_addr !== 32'h0) begin
      errors++;
      $display("FAIL t2_if_issue: req %b we %b addr %h want 1 0 0",
        bus.ext_req, bus.ext_we, bus.ext_addr);
    end
    tick();
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 ||
        bus.if_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL t2_if_done: vld %b data %h want 1 cafef00d",
        bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    tick();
    rd_word     = 32'h0BADF00D;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h180;
    tick();
    bus.if_req = 1'b0;
    #1;
    checks++;
    if (bus.ext_req !== 1'b1 ||
        bus.if_stall !== 1'b0) begin
      errors++;
      $display("FAIL fl_c1: req %b stall %b want 1 0",
        bus.ext_req, bus.if_stall);
    end
    tick();
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 ||
        bus.if_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL fl_pulse: vld %b data %h want 1 0badf00d",
        bus.if_valid, bus.if_rdata);
    end
    tick();
  endtask

  task automatic test_wait_states();
    int acc0;
    int pulses;
    tick();
    acc0         = accepts;
    pulses       = 0;
    ready_lat    = 5;
    rv_lat       = 2;
    rd_word      = 32'h55AA;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h80;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.mem_valid === 1'b1) pulses++;
      if (c <= 6) begin
        checks++;
        if (bus.ext_req !== 1'b1 ||
            bus.ext_addr !== 32'h80) begin
          errors++;
          $display("FAIL t3_hold c%0d: req %b addr %h want 1 80",
            c, bus.ext_req, bus.ext_addr);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.mem_valid !== 1'b1 ||
            bus.mem_rdata !== 32'h55AA) begin
          errors++;
          $display("FAIL t3_pulse: vld %b data %h want 1 55aa",
            bus.mem_valid, bus.mem_rdata);
        end
        bus.mem_req = 1'b0;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL t3_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (accepts - acc0 != 1) begin
      errors++;
      $display("FAIL t3_accepts: got %0d want 1",
        accepts - acc0);
    end
    ready_lat = 0;
    rv_lat    = 0;
  endtask

  task automatic test_timeout();
    int early;
    tick();
    early        = 0;
    rv_never     = 1'b1;
    rd_word      = 32'h77777777;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h200;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (bus.mem_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL t4_early: got %0d pulses want 0", early);
    end
    tick();
    checks++;
    if (bus.mem_valid !== 1'b1 ||
        bus.err !== 1'b1 ||
        bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL t4_to: vld %b err %b data %h want 1 1 0",
        bus.mem_valid, bus.err, bus.mem_rdata);
    end
    bus.mem_req = 1'b0;
    tick();
    inject_req++;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.mem_valid !== 1'b0 ||
          bus.if_valid !== 1'b0 ||
          bus.ext_req !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL t4_late: got %0d bad cycles want 0", early);
    end
    rv_never    = 1'b0;
    rd_word     = 32'h13579BDF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    repeat (3) tick();
    checks++;
    if (bus.if_valid !== 1'b1 ||
        bus.err !== 1'b0 ||
        bus.if_rdata !== 32'h13579BDF) begin
      errors++;
      $display("FAIL t4_next: vld %b err %b data %h want 1 0 13579bdf",
        bus.if_valid, bus.err, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    int bad;
    tick();
    rv_lat       = 6;
    rd_word      = 32'hA5A5A5A5;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h400;
    tick();
    tick();
    checks++;
    if (bus.ext_req !== 1'b0 ||
        bus.ext_addr !== 32'h400) begin
      errors++;
      $display("FAIL t5_wait: req %b addr %h want 0 400",
        bus.ext_req, bus.ext_addr);
    end
    tick();
    rst         = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    checks++;
    if (bus.ext_addr !== '0 ||
        bus.if_rdata !== '0) begin
      errors++;
      $display("FAIL t5_async: addr %h idata %h want 0 0",
        bus.ext_addr, bus.if_rdata);
    end
    tick();
    rst = 1'b1;
    bad = 0;
    for (int c = 4; c <= 12; c++) begin
      tick();
      if (bus.mem_valid !== 1'b0 ||
          bus.if_valid !== 1'b0 ||
          bus.err !== 1'b0 ||
          bus.ext_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL t5_quiet: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (bus.mem_rdata !== '0 ||
        bus.ext_addr !== '0 ||
        bus.ext_we !== 1'b0) begin
      errors++;
      $display("FAIL t5_zero: mdata %h addr %h we %b want 0",
        bus.mem_rdata, bus.ext_addr, bus.ext_we);
    end
    rv_lat = 0;
  endtask

  task automatic test_starve();
    int mem_cnt;
    int if_cnt;
    int first_if;
    tick();
    mem_cnt      = 0;
    if_cnt       = 0;
    first_if     = -1;
    rd_word      = 32'h600D600D;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h500;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h600;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.mem_valid === 1'b1) mem_cnt++;
      if (bus.if_valid === 1'b1) begin
        if_cnt++;
        if (first_if < 0) first_if = mem_cnt;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    checks++;
    if (first_if != 4) begin
      errors++;
      $display("FAIL t6_guard: IF after %0d MEM grants want 4",
        first_if);
    end
    checks++;
    if (if_cnt != 1 || mem_cnt != 6) begin
      errors++;
      $display("FAIL t6_mix: if %0d mem %0d want 1 6",
        if_cnt, mem_cnt);
    end
`else
    checks++;
    if (if_cnt != 0) begin
      errors++;
      $display("FAIL t6_strict: IF grants %0d want 0", if_cnt);
    end
    checks++;
    if (mem_cnt != 7) begin
      errors++;
      $display("FAIL t6_mem: MEM grants %0d want 7", mem_cnt);
    end
`endif
    bus.mem_req = 1'b0;
    bus.if_req  = 1'b0;
    repeat (6) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    test_reset();
    test_if_read();
    test_both_req();
    test_flush();
    test_wait_states();
    test_timeout();
    test_reset_in_wait();
    test_starve();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
